// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
//   Memory handshake between the multi-cycle controller and the unified
//   instruction/data memory.
//   mem_req   : access request (controller -> memory)
//   mem_write : write access, valid with mem_req (controller -> memory)
//   adr_src   : address select, 0 = PC, 1 = ALU output register (controller -> datapath)
//   mem_ready : memory completed the current access this cycle (memory -> controller)
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multi-cycle RV32I core (lw, sw, R-type, I-type ALU,
//   branch, jal). Sequences one shared ALU and one unified memory, stalling
//   on the memory ready handshake.
//
//   Optional build macro MULTICYCLE_CTRL_INSTRET_EN adds a 32-bit retired
//   instruction counter on output instret.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   mem            : memory handshake interface (master side)
//   opcode, zero   : instruction opcode and ALU zero flag
//   ir_write, pc_write, reg_write              : datapath write enables
//   alu_src_a, alu_src_b, result_src, imm_src  : datapath selects
//   alu_op         : to alu_decoder (00 add, 01 sub, 10 funct-decoded)
//   illegal        : sticky unsupported-opcode flag
//   state_o        : current state encoding, debug
//   instret        : retired instruction count (macro build only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instr at PC; on mem_ready load IR/old_pc, PC <= PC+4
// DECODE   | compute branch/jump target old_pc+imm into ALU out reg
// MEMADR   | compute rs1+imm load/store address
// MEMREAD  | read data memory, wait for mem_ready
// MEMWB    | write memory data register into rd
// MEMWRITE | write data memory, wait for mem_ready
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// ALUWB    | write ALU output register into rd
// BRANCH   | compare rs1/rs2, PC <= target when zero
// JAL      | PC <= target, ALU computes old_pc+4 for rd
// ILLEGAL  | unsupported opcode, parked until reset
module multicycle_controller #(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_controller_if.master       mem,
  input  logic [6:0]                    opcode,
  input  logic                          zero,
  output logic                          ir_write,
  output logic                          pc_write,
  output logic                          reg_write,
  output logic [1:0]                    alu_src_a,
  output logic [1:0]                    alu_src_b,
  output logic [1:0]                    result_src,
  output logic [2:0]                    imm_src,
  output logic [1:0]                    alu_op,
  output logic                          illegal,
  output logic [3:0]                    state_o
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  ,
  output logic [31:0]                   instret
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // Only the FETCH reset state is defined; reject anything else at elaboration.
  if (RESET_STATE_FETCH != 1) begin : g_bad_reset_state
    $error("multicycle_controller: RESET_STATE_FETCH must be 1");
  end

  state_t state_q, state_d;
  logic   illegal_q;

  logic mem_req_c, mem_write_c, adr_src_c;
  logic ir_write_c, pc_write_c, reg_write_c;

  function automatic logic [2:0] imm_for(input logic [6:0] op);
    case (op)
      OP_SW:   return 3'b001;
      OP_B:    return 3'b010;
      OP_JAL:  return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     illegal_q <= 1'b0;
    else if (state_d == S_ILLEGAL)  illegal_q <= 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem.mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      // Unused encodings restart instruction fetch.
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    adr_src_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = 3'b000;
    alu_op      = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = mem.mem_ready;
        pc_write_c = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = imm_for(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = imm_for(opcode);
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        result_src  = 2'b01;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:  reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write_c = zero;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces the enables low even though the held state is FETCH.
  assign mem.mem_req   = mem_req_c   & rst_n;
  assign mem.mem_write = mem_write_c & rst_n;
  assign mem.adr_src   = adr_src_c;
  assign ir_write      = ir_write_c  & rst_n;
  assign pc_write      = pc_write_c  & rst_n;
  assign reg_write     = reg_write_c & rst_n;
  assign illegal       = illegal_q;
  assign state_o       = state_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret_q;
  logic        retire;

  // JAL retires through ALUWB, so it is counted exactly once.
  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                   (state_q == S_ALUWB) || (state_q == S_BRANCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       zero = 1'b0;
  logic       ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret;
`endif
  int total = 0;
  int bad = 0;

  multicycle_controller_if mem_if ();

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (mem_if.master),
    .opcode     (opcode),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state_o    (state_o)
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    mem_if.mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick;
    #1;
    total++;
    if (state_o !== 4'd0) begin $display("FAIL reset_state got=%0d exp=0", state_o); bad++; end
    total++;
    if ({mem_if.mem_req, mem_if.mem_write, ir_write, pc_write, reg_write} !== 5'b0) begin
      $display("FAIL reset_enables got=%b exp=00000", {mem_if.mem_req, mem_if.mem_write, ir_write, pc_write, reg_write}); bad++;
    end
    total++;
    if (illegal !== 1'b0) begin $display("FAIL reset_illegal got=%b exp=0", illegal); bad++; end
    tick;
    mem_if.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if ({mem_if.mem_req, ir_write, pc_write} !== 3'b100) begin
      $display("FAIL reset_release_fetch got=%b exp=100", {mem_if.mem_req, ir_write, pc_write}); bad++;
    end
  endtask

  task automatic test_fetch_wait;
    opcode = 7'b0110011;
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({state_o, mem_if.mem_req, mem_if.adr_src, ir_write, pc_write} !== 8'b0000_1000) begin
        $display("FAIL fetch_wait cyc=%0d got=%b exp=00001000", i, {state_o, mem_if.mem_req, mem_if.adr_src, ir_write, pc_write}); bad++;
      end
      tick;
    end
    mem_if.mem_ready = 1'b1;
    #1;
    total++;
    if ({ir_write, pc_write} !== 2'b11) begin $display("FAIL fetch_ready got=%b exp=11", {ir_write, pc_write}); bad++; end
    repeat (4) tick;
    total++;
    if (state_o !== 4'd0) begin $display("FAIL fetch_wait_end got=%0d exp=0", state_o); bad++; end
  endtask

  task automatic test_r_type;
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
    logic [1:0] exp_op [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
    opcode = 7'b0110011;
    mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state_o !== exp_st[i]) begin $display("FAIL r_state cyc=%0d got=%0d exp=%0d", i, state_o, exp_st[i]); bad++; end
      total++;
      if (reg_write !== (i == 3)) begin $display("FAIL r_reg_write cyc=%0d got=%b exp=%b", i, reg_write, (i == 3)); bad++; end
      total++;
      if (alu_op !== exp_op[i]) begin $display("FAIL r_alu_op cyc=%0d got=%b exp=%b", i, alu_op, exp_op[i]); bad++; end
      tick;
    end
    total++;
    if (state_o !== 4'd0) begin $display("FAIL r_end got=%0d exp=0", state_o); bad++; end
  endtask

  task automatic test_lw_wait;
    logic       rdy    [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic [1:0] exp_rs [7] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    opcode = 7'b0000011;
    for (int i = 0; i < 7; i++) begin
      mem_if.mem_ready = rdy[i];
      #1;
      total++;
      if (state_o !== exp_st[i]) begin $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state_o, exp_st[i]); bad++; end
      total++;
      if ({mem_if.mem_req, mem_if.adr_src} !== {(i == 0) || (i >= 3 && i <= 5), (i >= 3 && i <= 5)}) begin
        $display("FAIL lw_req_adr cyc=%0d got=%b", i, {mem_if.mem_req, mem_if.adr_src}); bad++;
      end
      total++;
      if ({reg_write, result_src} !== {(i == 6), exp_rs[i]}) begin
        $display("FAIL lw_wb cyc=%0d got=%b exp=%b", i, {reg_write, result_src}, {(i == 6), exp_rs[i]}); bad++;
      end
      tick;
    end
    #1;
    total++;
    if (state_o !== 4'd0) begin $display("FAIL lw_end got=%0d exp=0", state_o); bad++; end
  endtask

  task automatic test_sw;
    logic       rdy    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_ready = rdy[i];
      #1;
      total++;
      if (state_o !== exp_st[i]) begin $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, state_o, exp_st[i]); bad++; end
      total++;
      if (mem_if.mem_write !== (i >= 3)) begin $display("FAIL sw_mem_write cyc=%0d got=%b exp=%b", i, mem_if.mem_write, (i >= 3)); bad++; end
      total++;
      if (imm_src !== ((i == 1 || i == 2) ? 3'b001 : 3'b000)) begin $display("FAIL sw_imm cyc=%0d got=%b", i, imm_src); bad++; end
      tick;
    end
    total++;
    if (state_o !== 4'd0) begin $display("FAIL sw_end got=%0d exp=0", state_o); bad++; end
  endtask

  task automatic test_branch;
    logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd9};
    opcode = 7'b1100011;
    mem_if.mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 3; i++) begin
        #1;
        total++;
        if (state_o !== exp_st[i]) begin $display("FAIL br_state z=%0d cyc=%0d got=%0d exp=%0d", z, i, state_o, exp_st[i]); bad++; end
        if (i == 1) begin
          total++;
          if ({imm_src, pc_write} !== 4'b0100) begin $display("FAIL br_decode got=%b exp=0100", {imm_src, pc_write}); bad++; end
        end
        if (i == 2) begin
          total++;
          if ({pc_write, alu_op, result_src} !== {z[0], 4'b0100}) begin
            $display("FAIL br_exec z=%0d got=%b exp=%b", z, {pc_write, alu_op, result_src}, {z[0], 4'b0100}); bad++;
          end
        end
        tick;
      end
      total++;
      if (state_o !== 4'd0) begin $display("FAIL br_end z=%0d got=%0d exp=0", z, state_o); bad++; end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal;
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd10, 4'd8};
    opcode = 7'b1101111;
    mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state_o !== exp_st[i]) begin $display("FAIL jal_state cyc=%0d got=%0d exp=%0d", i, state_o, exp_st[i]); bad++; end
      total++;
      if ({pc_write, reg_write} !== {(i == 0 || i == 2), (i == 3)}) begin
        $display("FAIL jal_enables cyc=%0d got=%b", i, {pc_write, reg_write}); bad++;
      end
      if (i == 1) begin
        total++;
        if (imm_src !== 3'b011) begin $display("FAIL jal_imm got=%b exp=011", imm_src); bad++; end
      end
      if (i == 2) begin
        total++;
        if ({alu_src_a, alu_src_b} !== 4'b0110) begin $display("FAIL jal_alu_src got=%b exp=0110", {alu_src_a, alu_src_b}); bad++; end
      end
      if (i == 3) begin
        total++;
        if (result_src !== 2'b00) begin $display("FAIL jal_result_src got=%b exp=00", result_src); bad++; end
      end
      tick;
    end
    total++;
    if (state_o !== 4'd0) begin $display("FAIL jal_end got=%0d exp=0", state_o); bad++; end
  endtask

  task automatic test_reset_mid;
    opcode = 7'b0110011;
    mem_if.mem_ready = 1'b1;
    repeat (2) tick;
    total++;
    if (state_o !== 4'd6) begin $display("FAIL mid_pre got=%0d exp=6", state_o); bad++; end
    rst_n = 1'b0;
    tick;
    total++;
    if ({state_o, reg_write} !== 5'b0000_0) begin $display("FAIL mid_abandon got=%b exp=00000", {state_o, reg_write}); bad++; end
    rst_n = 1'b1;
  endtask

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  task automatic test_instret;
    opcode = 7'b0110011;
    mem_if.mem_ready = 1'b1;
    repeat (12) tick;
    opcode = 7'b0100011;
    repeat (4) tick;
    total++;
    if (instret !== 32'd4) begin $display("FAIL instret_count got=%0d exp=4", instret); bad++; end
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    opcode = 7'b0110011;
    repeat (4) tick;
    total++;
    if (instret !== 32'd0) begin $display("FAIL instret_wrap got=%h exp=00000000", instret); bad++; end
  endtask
`endif

  task automatic test_illegal;
    opcode = 7'b0110111;
    mem_if.mem_ready = 1'b1;
    repeat (2) tick;
    for (int i = 0; i < 12; i++) begin
      #1;
      total++;
      if ({state_o, illegal, mem_if.mem_req, pc_write, ir_write, reg_write} !== 9'b1011_1_0000) begin
        $display("FAIL illegal_hold cyc=%0d got=%b exp=101110000", i, {state_o, illegal, mem_if.mem_req, pc_write, ir_write, reg_write}); bad++;
      end
      tick;
    end
    rst_n = 1'b0;
    #2;
    total++;
    if ({state_o, illegal, mem_if.mem_req} !== 6'b0000_0_0) begin
      $display("FAIL illegal_async_clear got=%b exp=000000", {state_o, illegal, mem_if.mem_req}); bad++;
    end
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_r_type();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jal();
    test_reset_mid();
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    test_instret();
`endif
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
